// File: rtl/fsk_pkg.sv
// rtl/fsk_pkg.sv - shared defaults, state encoding and sine table helper for the FSK tone generator
package fsk_pkg;

  localparam int FSK_PHASE_W   = 16;
  localparam int FSK_ADDR_W    = 9;
  localparam int FSK_DATA_W    = 8;
  localparam int FSK_ROM_DEPTH = 2 ** FSK_ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    TONE = 1'b1
  } state_t;

  // pi/2 in Q30 fixed point
  localparam longint PI_HALF_Q30 = 64'sd1686629713;

  // round(amp * sin(2*pi*k / 2**addr_w)) using integer-only Taylor series on a quarter wave,
  // evaluated at elaboration so the table is a plain constant ROM
  function automatic int sine_entry(input int k, input int addr_w, input int amp);
    longint depth, half, quarter, q, x, term, sum, val;
    bit     neg;
    depth   = longint'(1) << addr_w;
    half    = depth / 2;
    quarter = depth / 4;
    q       = longint'(k) % depth;
    neg     = (q >= half);
    if (neg) q = q - half;
    if (q > quarter) q = half - q;
    x    = (PI_HALF_Q30 * q) / quarter;
    sum  = x;
    term = x;
    for (int n = 1; n <= 7; n++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    val = (longint'(amp) * sum + (longint'(1) << 29)) >>> 30;
    return int'(neg ? -val : val);
  endfunction

endpackage

// File: rtl/fsk_sine_rom.sv
// rtl/fsk_sine_rom.sv - full-wave signed sine ROM with combinational read
module fsk_sine_rom
  import fsk_pkg::*;
#(
  parameter int DATA_W = FSK_DATA_W,
  parameter int ADDR_W = FSK_ADDR_W,
  parameter int AMP    = 100
) (
  input  logic        [ADDR_W-1:0] addr,
  output logic signed [DATA_W-1:0] data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic signed [DATA_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic signed [DATA_W-1:0] ENTRY = DATA_W'(sine_entry(i, ADDR_W, AMP));
    assign rom[i] = ENTRY;
  end

  assign data = rom[addr];

endmodule

// File: rtl/fsk_tone_gen.sv
// rtl/fsk_tone_gen.sv - continuous-phase FSK sine generator: phase accumulator, per-bit sample counter, bit FSM
module fsk_tone_gen
  import fsk_pkg::*;
#(
  parameter int DATA_W  = FSK_DATA_W,
  parameter int ADDR_W  = FSK_ADDR_W,
  parameter int PHASE_W = FSK_PHASE_W,
  parameter int AMP     = 100,
  parameter int SPB     = 8
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      En,
  input  logic        [PHASE_W-1:0] f0_step,
  input  logic        [PHASE_W-1:0] f1_step,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic                      bit_ready,
  output logic signed [DATA_W-1:0]  sample,
  output logic                      sample_valid,
  output logic                      busy,
  output logic                      bit_done
);

  localparam int CNT_W = $clog2(SPB);

  state_t                   state, state_nxt;
  logic [PHASE_W-1:0]       phase;
  logic [PHASE_W-1:0]       step_r;
  logic [CNT_W-1:0]         cnt;
  logic signed [DATA_W-1:0] rom_data;
  logic                     last;
  logic                     accept;

  assign busy      = (state == TONE);
  assign last      = busy & En & (cnt == CNT_W'(SPB - 1));
  // no path from bit_valid, so the source may drive bit_valid from bit_ready
  assign bit_ready = (state == IDLE) | last;
  assign accept    = bit_valid & bit_ready;

  fsk_sine_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .AMP    (AMP)
  ) u_rom (
    .addr (phase[PHASE_W-1 -: ADDR_W]),
    .data (rom_data)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = TONE;
      TONE:    if (last) state_nxt = accept ? TONE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      phase        <= '0;
      cnt          <= '0;
      step_r       <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      bit_done     <= 1'b0;
    end else begin
      state        <= state_nxt;
      sample_valid <= 1'b0;
      bit_done     <= 1'b0;
      if (busy && En) begin
        sample       <= rom_data;
        sample_valid <= 1'b1;
        phase        <= phase + step_r;
        cnt          <= cnt + CNT_W'(1);
        bit_done     <= last;
      end
      // phase is left alone here so back-to-back bits stay phase-continuous
      if (accept) begin
        step_r <= bit_in ? f1_step : f0_step;
        cnt    <= '0;
      end
    end
  end

endmodule
